// File: rtl/gh_pkg.sv
// rtl/gh_pkg.sv - shared grade encodings, point values, screen limit, FSM states and saturating add
package gh_pkg;

  localparam logic [1:0] GRADE_NONE    = 2'd0;
  localparam logic [1:0] GRADE_GOOD    = 2'd1;
  localparam logic [1:0] GRADE_PERFECT = 2'd2;
  localparam logic [1:0] GRADE_MISS    = 2'd3;

  localparam logic [15:0] PTS_PERFECT = 16'd3;
  localparam logic [15:0] PTS_GOOD    = 16'd1;

  // Last visible pixel row of the playfield.
  localparam int unsigned SCREEN = 479;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_ZONE,
    ST_DONE
  } state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/note_judge_if.sv
// rtl/note_judge_if.sv - note tracker / fret button inputs and judgement outputs of the note judge
interface note_judge_if;
  logic [9:0]  i_yhigh;
  logic        i_btn;
  logic        o_hit;
  logic        o_miss;
  logic [1:0]  o_grade;
  logic [15:0] o_score;
  logic [7:0]  o_combo;

  modport master (
    output i_yhigh, i_btn,
    input  o_hit, o_miss, o_grade, o_score, o_combo
  );

  modport slave (
    input  i_yhigh, i_btn,
    output o_hit, o_miss, o_grade, o_score, o_combo
  );
endinterface

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - two-flop synchronizer plus registered rising-edge detector for the fret button
module btn_edge (
  input  logic gameclk,
  input  logic in_reset,
  input  logic i_raw,
  output logic o_press
);
  logic sync1_q, sync2_q, prev_q, press_q;

  // Synchronize the raw button, then emit a one-cycle registered pulse on each rise.
  always_ff @(posedge gameclk or negedge in_reset) begin
    if (!in_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= sync2_q & ~prev_q;
    end
  end

  assign o_press = press_q;
endmodule

// File: rtl/note_judge.sv
// rtl/note_judge.sv - note judge: hit-window FSM, grading, score and combo (option: NOTE_JUDGE_COMBO_MULT_EN)
module note_judge
  import gh_pkg::*;
#(
  parameter int unsigned ZONE_Y      = 420,
  parameter int unsigned GOOD_TOL    = 24,
  parameter int unsigned PERFECT_TOL = 8
) (
  input logic         gameclk,
  input logic         in_reset,
  note_judge_if.slave bus
);
  // A window that would extend past the bottom of the screen still closes at the screen edge.
  localparam int unsigned EXIT_Y = ((ZONE_Y + GOOD_TOL) < SCREEN) ? (ZONE_Y + GOOD_TOL) : SCREEN;

  logic        press;
  state_t      state_q, state_d;
  logic [9:0]  yprev_q;
  logic        hit_q, hit_d, miss_q, miss_d;
  logic [1:0]  grade_q, grade_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  combo_q, combo_d;

  logic [10:0] y_ext, d;
  logic        wrap, in_win, past_win, is_perfect;
  logic        judge_hit, judge_miss;
  logic [15:0] base_pts, hit_pts;

  btn_edge u_btn_edge (
    .gameclk (gameclk),
    .in_reset(in_reset),
    .i_raw   (bus.i_btn),
    .o_press (press)
  );

  // Distance to the strike line and the window / new-note qualifiers for this sample.
  always_comb begin
    y_ext      = {1'b0, bus.i_yhigh};
    d          = (y_ext >= 11'(ZONE_Y)) ? (y_ext - 11'(ZONE_Y)) : (11'(ZONE_Y) - y_ext);
    wrap       = bus.i_yhigh < yprev_q;
    in_win     = d <= 11'(GOOD_TOL);
    past_win   = y_ext > 11'(EXIT_Y);
    is_perfect = d <= 11'(PERFECT_TOL);
    base_pts   = is_perfect ? PTS_PERFECT : PTS_GOOD;
  end

`ifdef NOTE_JUDGE_COMBO_MULT_EN
  logic [15:0] mult;

  // Hit points scale with the combo held before this hit: 1 + combo/8, capped at 4.
  always_comb begin
    mult = 16'd4;
    if (combo_q[7:5] == 3'd0 && combo_q[4:3] != 2'b11) begin
      mult = 16'({1'b0, combo_q[4:3]} + 3'd1);
    end
    hit_pts = base_pts * mult;
  end
`else
  assign hit_pts = base_pts;
`endif

  // Judgement FSM: one verdict per note, then wait for the note to wrap back to the top.
  always_comb begin
    state_d    = state_q;
    judge_hit  = 1'b0;
    judge_miss = 1'b0;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    grade_d    = grade_q;
    score_d    = score_q;
    combo_d    = combo_q;
    case (state_q)
      ST_WAIT: begin
        if (in_win) state_d = ST_ZONE;
      end
      ST_ZONE: begin
        if (wrap) begin
          judge_miss = 1'b1;
          state_d    = ST_WAIT;
        end else if (press) begin
          judge_hit  = in_win;
          judge_miss = ~in_win;
          state_d    = ST_DONE;
        end else if (past_win) begin
          judge_miss = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (wrap) state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
    if (judge_hit) begin
      hit_d   = 1'b1;
      grade_d = is_perfect ? GRADE_PERFECT : GRADE_GOOD;
      score_d = sat_add16(score_q, hit_pts);
      combo_d = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
    end
    if (judge_miss) begin
      miss_d  = 1'b1;
      grade_d = GRADE_MISS;
      combo_d = 8'd0;
    end
  end

  // State, outputs and previous-position register; reset drops any pending note silently.
  always_ff @(posedge gameclk or negedge in_reset) begin
    if (!in_reset) begin
      state_q <= ST_WAIT;
      yprev_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      grade_q <= GRADE_NONE;
      score_q <= '0;
      combo_q <= '0;
    end else begin
      state_q <= state_d;
      yprev_q <= bus.i_yhigh;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      grade_q <= grade_d;
      score_q <= score_d;
      combo_q <= combo_d;
    end
  end

  assign bus.o_hit   = hit_q;
  assign bus.o_miss  = miss_q;
  assign bus.o_grade = grade_q;
  assign bus.o_score = score_q;
  assign bus.o_combo = combo_q;
endmodule

// File: tb/tb_note_judge.sv
// tb/tb_note_judge.sv - self-checking bench for note_judge with a per-cycle reference model
module tb_note_judge;
  localparam int ZONE = 420;
  localparam int GOOD = 24;
  localparam int PERF = 8;

  logic gameclk  = 1'b0;
  logic in_reset = 1'b0;

  note_judge_if bus ();

  note_judge #(.ZONE_Y(ZONE), .GOOD_TOL(GOOD), .PERFECT_TOL(PERF)) dut (
    .gameclk (gameclk),
    .in_reset(in_reset),
    .bus     (bus)
  );

  always #5 gameclk = ~gameclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: note phase 0 = approaching, 1 = inside window, 2 = already judged.
  int m_phase = 0, m_prev = 0, m_grade = 0, m_score = 0, m_combo = 0;
  bit m_hit = 0, m_miss = 0;
  bit r1 = 0, r2 = 0, r3 = 0, r4 = 0;
  int my, md, mult;
  bit mpress, mwrap, jhit, jmiss;

  always @(posedge gameclk or negedge in_reset) begin
    if (!in_reset) begin
      m_phase = 0; m_prev = 0; m_grade = 0; m_score = 0; m_combo = 0;
      m_hit = 0; m_miss = 0; r1 = 0; r2 = 0; r3 = 0; r4 = 0;
    end else begin
      my     = int'(bus.i_yhigh);
      mpress = r3 && !r4;
      r4 = r3; r3 = r2; r2 = r1; r1 = bus.i_btn;
      md     = (my > ZONE) ? my - ZONE : ZONE - my;
      mwrap  = my < m_prev;
      jhit = 0; jmiss = 0;
      if (m_phase == 0) begin
        if (md <= GOOD) m_phase = 1;
      end else if (m_phase == 1) begin
        if (mwrap) begin
          jmiss = 1; m_phase = 0;
        end else if (mpress || my > ZONE + GOOD) begin
          if (mpress && md <= GOOD) jhit = 1; else jmiss = 1;
          m_phase = 2;
        end
      end else if (mwrap) begin
        m_phase = 0;
      end
      m_hit = jhit; m_miss = jmiss;
      if (jhit) begin
`ifdef NOTE_JUDGE_COMBO_MULT_EN
        mult = 1 + m_combo / 8;
        if (mult > 4) mult = 4;
`else
        mult = 1;
`endif
        m_grade = (md <= PERF) ? 2 : 1;
        m_score = m_score + ((md <= PERF) ? 3 : 1) * mult;
        if (m_score > 65535) m_score = 65535;
        if (m_combo < 255) m_combo = m_combo + 1;
      end
      if (jmiss) begin
        m_grade = 3; m_combo = 0;
      end
      m_prev = my;
    end
  end

  // Every cycle, the DUT outputs must agree with the model.
  always @(negedge gameclk) begin
    chk("cyc_hit",   int'(bus.o_hit),   int'(m_hit));
    chk("cyc_miss",  int'(bus.o_miss),  int'(m_miss));
    chk("cyc_grade", int'(bus.o_grade), m_grade);
    chk("cyc_score", int'(bus.o_score), m_score);
    chk("cyc_combo", int'(bus.o_combo), m_combo);
  end

  task automatic step(input int y, input bit b);
    bus.i_yhigh = 10'(y);
    bus.i_btn   = b;
    @(posedge gameclk);
    #1;
  endtask

  typedef struct {
    int rise; int chk_y; int grade; int hit; int score; int combo;
  } ramp_t;

  ramp_t ramps[7] = '{
    '{417, 420, 2, 1, 3, 1},
    '{437, 440, 1, 1, 4, 2},
    '{ -1, 445, 3, 0, 4, 0},
    '{425, 428, 2, 1, 7, 1},
    '{426, 429, 1, 1, 8, 2},
    '{441, 444, 1, 1, 9, 3},
    '{442, 445, 3, 0, 9, 0}
  };

  task automatic ramp(input ramp_t r);
    for (int y = 0; y <= 510; y++) begin
      step(y, r.rise >= 0 && y >= r.rise && y < r.rise + 4);
      if (y == r.chk_y) begin
        chk("ramp_hit",   int'(bus.o_hit),   r.hit);
        chk("ramp_miss",  int'(bus.o_miss),  1 - r.hit);
        chk("ramp_grade", int'(bus.o_grade), r.grade);
        chk("ramp_score", int'(bus.o_score), r.score);
        chk("ramp_combo", int'(bus.o_combo), r.combo);
      end
    end
  endtask

  task automatic quick_note();
    step(0, 0); step(420, 1); step(420, 1); step(420, 0); step(420, 0);
    chk("quick_hit", int'(bus.o_hit), 1);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_hit"},   int'(bus.o_hit),   0);
    chk({tag, "_miss"},  int'(bus.o_miss),  0);
    chk({tag, "_grade"}, int'(bus.o_grade), 0);
    chk({tag, "_score"}, int'(bus.o_score), 0);
    chk({tag, "_combo"}, int'(bus.o_combo), 0);
  endtask

  int s0;

  initial begin
    bus.i_yhigh = '0;
    bus.i_btn   = 1'b0;
    repeat (3) @(posedge gameclk);
    #1;
    check_cleared("reset");
    in_reset = 1'b1;

    foreach (ramps[i]) ramp(ramps[i]);

    // Early press ignored, one PERFECT, later press in the judged phase ignored.
    for (int y = 0; y <= 510; y++) begin
      step(y, (y >= 100 && y < 104) || (y >= 420 && y < 424) || (y >= 430 && y < 434));
      if (y == 103) chk("early_hit", int'(bus.o_hit), 0);
      if (y == 103) chk("early_score", int'(bus.o_score), 9);
      if (y == 423) chk("second_hit", int'(bus.o_hit), 1);
      if (y == 423) chk("second_grade", int'(bus.o_grade), 2);
      if (y == 423) chk("second_score", int'(bus.o_score), 12);
      if (y == 433) chk("third_hit", int'(bus.o_hit), 0);
      if (y == 433) chk("third_score", int'(bus.o_score), 12);
      if (y == 445) chk("done_miss", int'(bus.o_miss), 0);
    end

    // Reset while the note sits on the strike line inside the window.
    for (int y = 0; y <= 420; y++) step(y, 0);
    #2 in_reset = 1'b0;
    #1 check_cleared("async_reset");
    @(posedge gameclk);
    @(posedge gameclk);
    #1 in_reset = 1'b1;
    ramp('{417, 420, 2, 1, 3, 1});

    // Combo saturates at 255.
    for (int i = 0; i < 260; i++) quick_note();
    chk("combo_sat", int'(bus.o_combo), 255);
`ifndef NOTE_JUDGE_COMBO_MULT_EN
    chk("combo_sat_score", int'(bus.o_score), 783);
`endif

    // A note that wraps while inside the window is a miss.
    step(0, 0); step(420, 0); step(0, 0);
    chk("wrap_miss", int'(bus.o_miss), 1);
    chk("wrap_hit", int'(bus.o_hit), 0);
    chk("wrap_grade", int'(bus.o_grade), 3);
    chk("wrap_combo", int'(bus.o_combo), 0);

`ifdef NOTE_JUDGE_COMBO_MULT_EN
    for (int i = 0; i < 16; i++) quick_note();
    chk("mult_combo16", int'(bus.o_combo), 16);
    s0 = m_score;
    quick_note();
    chk("mult_score", int'(bus.o_score), (s0 + 9 > 65535) ? 65535 : s0 + 9);
`else
    s0 = m_score;
    quick_note();
    chk("plain_score", int'(bus.o_score), s0 + 3);
`endif

    step(0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
